char_display_buffer: RTL and testbench
======================================

CHAR_DISPLAY_BUFFER -- requirements
Module: char_display_buffer

Interface
REQ-001 Parameter CHAR_WIDTH, default 7, bits per stored glyph code.
REQ-002 Parameter COLS, default 80, glyph columns per row.
REQ-003 Parameter ROWS, default 60, glyph rows per screen.
REQ-004 Parameter COL_BITS 7, ROW_BITS 6, ADDR_BITS 13; each SHALL be wide enough for COLS-1, ROWS-1 and COLS*ROWS-1 respectively.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpuWriteEn  in  1  CPU write request, qualified by cpuReady.
REQ-008 cpuCol / cpuRow  in  COL_BITS / ROW_BITS  CPU logical glyph position.
REQ-009 writeData  in  CHAR_WIDTH  glyph code to write.
REQ-010 outputCPU  out  CHAR_WIDTH  registered read data at the CPU position.
REQ-011 hGlyphVGA / vGlyphVGA  in  COL_BITS / ROW_BITS  VGA logical glyph position.
REQ-012 outputVGA  out  CHAR_WIDTH  registered read data at the VGA position.
REQ-013 clearStart  in  1  one-cycle pulse: fill whole screen with fillChar.
REQ-014 scrollUp  in  1  one-cycle pulse: scroll screen up one row, blank new bottom row.
REQ-015 fillChar  in  CHAR_WIDTH  glyph used for every fill; sampled when a command is accepted.
REQ-016 cpuReady  out  1  high only in IDLE.
REQ-017 busy  out  1  high while a clear or row-blank is running.
REQ-018 rowOffset  out  ROW_BITS  current physical row of logical row 0.

Function
REQ-019 Storage SHALL be COLS*ROWS entries of CHAR_WIDTH bits, one write port, two read ports.
REQ-020 Physical row = (logicalRow + rowOffset) mod ROWS, computed without a divider; physical address = physRow*COLS + col.
REQ-021 Both read outputs SHALL have exactly one cycle latency: position presented at edge N, data valid after edge N+1.
REQ-022 A read with col>=COLS or row>=ROWS SHALL return 0 on that port one cycle later.
REQ-023 A CPU write SHALL occur only when cpuWriteEn=1, cpuReady=1, col<COLS and row<ROWS; otherwise it is dropped, not queued.
REQ-024 Read-during-write to the same address on any port SHALL return the old data.
REQ-025 FSM states: IDLE, CLEAR_ALL, CLEAR_ROW.
REQ-026 IDLE + clearStart: latch fillChar, set rowOffset=0, go CLEAR_ALL; no CPU write in that cycle.
REQ-027 CLEAR_ALL SHALL write fillChar to physical addresses 0..COLS*ROWS-1, one per cycle, ascending, then return to IDLE: exactly COLS*ROWS busy cycles.
REQ-028 IDLE + scrollUp (clearStart=0): latch fillChar, set rowOffset=(rowOffset+1) mod ROWS (ROWS-1 wraps to 0), go CLEAR_ROW targeting the old rowOffset physical row.
REQ-029 CLEAR_ROW SHALL write fillChar to columns 0..COLS-1 of the target row, one per cycle, then return to IDLE: exactly COLS busy cycles.
REQ-030 clearStart and scrollUp in the same IDLE cycle: clearStart wins, scrollUp is discarded.
REQ-031 clearStart or scrollUp outside IDLE SHALL be ignored.
REQ-032 busy and ~cpuReady SHALL be asserted in the cycle after command acceptance and deassert on the edge leaving the last fill write.
REQ-033 Reads SHALL continue during CLEAR_ALL and CLEAR_ROW, using the updated rowOffset.

Reset
REQ-034 On reset: state IDLE, rowOffset=0, busy=0, cpuReady=1, outputCPU=0, outputVGA=0, fill counters 0.
REQ-035 Reset during CLEAR_ALL or CLEAR_ROW SHALL abort the fill immediately; already-written cells keep fillChar, the rest are unchanged.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-037 Write 0x41 at (col 5,row 2), read CPU and VGA at (5,2) -> both outputs 0x41 exactly one cycle after the address is presented.
REQ-038 clearStart with fillChar=0x20 -> busy high for exactly 4800 cycles, every cell reads 0x20 afterwards, CPU writes during busy are dropped.
REQ-039 Write row index to column 0 of rows 0..59, scrollUp with fillChar=0 -> rowOffset=1, logical row r reads r+1 for r<59, logical row 59 reads 0 across all 80 columns after 80 busy cycles.
REQ-040 60 consecutive scrollUp commands -> rowOffset wraps 59->0, logical row contents consistent after each.
REQ-041 clearStart and scrollUp in the same cycle -> CLEAR_ALL only, rowOffset=0, busy 4800 cycles.
REQ-042 Assert reset at cycle 100 of CLEAR_ALL -> next cycle busy=0, cpuReady=1, rowOffset=0; cells 0..99 hold fillChar, cell 100 is unchanged; out-of-range read (col 80) returns 0.

Source files
------------

// File: rtl/char_display_buffer.sv
// Character display buffer: dual-read glyph store with CPU write port,
// hardware screen clear and row-offset scrolling with fill of the new bottom row.
module char_display_buffer #(
  parameter int CHAR_WIDTH = 7,
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int COL_BITS   = 7,
  parameter int ROW_BITS   = 6,
  parameter int ADDR_BITS  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuWriteEn,
  input  logic [COL_BITS-1:0]   cpuCol,
  input  logic [ROW_BITS-1:0]   cpuRow,
  input  logic [CHAR_WIDTH-1:0] writeData,
  output logic [CHAR_WIDTH-1:0] outputCPU,
  input  logic [COL_BITS-1:0]   hGlyphVGA,
  input  logic [ROW_BITS-1:0]   vGlyphVGA,
  output logic [CHAR_WIDTH-1:0] outputVGA,
  input  logic                  clearStart,
  input  logic                  scrollUp,
  input  logic [CHAR_WIDTH-1:0] fillChar,
  output logic                  cpuReady,
  output logic                  busy,
  output logic [ROW_BITS-1:0]   rowOffset
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ALL = 2'd1,
    CLEAR_ROW = 2'd2
  } stateType;

  stateType                state;
  stateType                nextState;
  logic [CHAR_WIDTH-1:0]   mem [CELLS];
  logic [ADDR_BITS-1:0]    fillCount;
  logic [ROW_BITS-1:0]     targetRow;
  logic [CHAR_WIDTH-1:0]   fillLatch;
  logic [ADDR_BITS-1:0]    cpuAddr;
  logic [ADDR_BITS-1:0]    vgaAddr;
  logic                    cpuOk;
  logic                    vgaOk;
  logic                    memWe;
  logic [ADDR_BITS-1:0]    memAddr;
  logic [CHAR_WIDTH-1:0]   memData;

  function automatic logic inRange(input logic [COL_BITS-1:0] col,
                                   input logic [ROW_BITS-1:0] row);
    return (int'(col) < COLS) && (int'(row) < ROWS);
  endfunction

  // Both operands are below ROWS for in-range rows, so one conditional subtract replaces the modulo.
  function automatic logic [ADDR_BITS-1:0] physAddr(input logic [COL_BITS-1:0] col,
                                                    input logic [ROW_BITS-1:0] row,
                                                    input logic [ROW_BITS-1:0] offset);
    logic [ROW_BITS:0] sum;
    sum = {1'b0, row} + {1'b0, offset};
    if (sum >= (ROW_BITS+1)'(ROWS)) begin
      sum = sum - (ROW_BITS+1)'(ROWS);
    end else begin
      sum = sum;
    end
    return ADDR_BITS'(sum) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
  endfunction

  // Logical-to-physical translation for both read positions.
  always_comb begin
    cpuAddr = physAddr(cpuCol, cpuRow, rowOffset);
    vgaAddr = physAddr(hGlyphVGA, vGlyphVGA, rowOffset);
    cpuOk   = inRange(cpuCol, cpuRow);
    vgaOk   = inRange(hGlyphVGA, vGlyphVGA);
  end

  // Next-state decode and write-port arbitration between CPU and fill engine.
  always_comb begin
    nextState = state;
    memWe     = 1'b0;
    memAddr   = '0;
    memData   = '0;
    case (state)
      IDLE: begin
        if (clearStart) begin
          nextState = CLEAR_ALL;
        end else if (scrollUp) begin
          nextState = CLEAR_ROW;
        end else begin
          nextState = IDLE;
        end
        if (cpuWriteEn && cpuOk && !clearStart) begin
          memWe   = 1'b1;
          memAddr = cpuAddr;
          memData = writeData;
        end else begin
          memWe   = 1'b0;
        end
      end
      CLEAR_ALL: begin
        memWe   = 1'b1;
        memAddr = fillCount;
        memData = fillLatch;
        if (fillCount == ADDR_BITS'(CELLS - 1)) begin
          nextState = IDLE;
        end else begin
          nextState = CLEAR_ALL;
        end
      end
      CLEAR_ROW: begin
        memWe   = 1'b1;
        memAddr = ADDR_BITS'(targetRow) * ADDR_BITS'(COLS) + fillCount;
        memData = fillLatch;
        if (fillCount == ADDR_BITS'(COLS - 1)) begin
          nextState = IDLE;
        end else begin
          nextState = CLEAR_ROW;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Fill counter, command latches, scroll offset and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      fillCount <= '0;
      fillLatch <= '0;
      targetRow <= '0;
      rowOffset <= '0;
      busy      <= 1'b0;
      cpuReady  <= 1'b1;
    end else begin
      busy     <= (nextState != IDLE);
      cpuReady <= (nextState == IDLE);
      if (state == IDLE || nextState == IDLE) begin
        fillCount <= '0;
      end else begin
        fillCount <= fillCount + ADDR_BITS'(1);
      end
      if (state == IDLE && clearStart) begin
        fillLatch <= fillChar;
        rowOffset <= '0;
      end else if (state == IDLE && scrollUp) begin
        fillLatch <= fillChar;
        targetRow <= rowOffset;
        rowOffset <= (rowOffset == ROW_BITS'(ROWS - 1)) ? '0 : rowOffset + ROW_BITS'(1);
      end
    end
  end

  // Registered read ports; out-of-range positions read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      outputCPU <= '0;
      outputVGA <= '0;
    end else begin
      outputCPU <= cpuOk ? mem[cpuAddr] : '0;
      outputVGA <= vgaOk ? mem[vgaAddr] : '0;
    end
  end

  // Glyph storage; reset only blocks the write so an aborted fill stops at once.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      mem[memAddr] <= memData;
    end
  end

endmodule

// File: tb/tb_char_display_buffer.sv
// Randomized bench for char_display_buffer against a queue-based screen model.
module tb_char_display_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpuWriteEn = 1'b0;
  logic [6:0] cpuCol = 7'd0;
  logic [5:0] cpuRow = 6'd0;
  logic [6:0] writeData = 7'd0;
  logic [6:0] outputCPU;
  logic [6:0] hGlyphVGA = 7'd0;
  logic [5:0] vGlyphVGA = 6'd0;
  logic [6:0] outputVGA;
  logic       clearStart = 1'b0;
  logic       scrollUp = 1'b0;
  logic [6:0] fillChar = 7'd0;
  logic       cpuReady;
  logic       busy;
  logic [5:0] rowOffset;

  char_display_buffer dut (
    .clk(clk), .reset(reset), .cpuWriteEn(cpuWriteEn), .cpuCol(cpuCol), .cpuRow(cpuRow),
    .writeData(writeData), .outputCPU(outputCPU), .hGlyphVGA(hGlyphVGA), .vGlyphVGA(vGlyphVGA),
    .outputVGA(outputVGA), .clearStart(clearStart), .scrollUp(scrollUp), .fillChar(fillChar),
    .cpuReady(cpuReady), .busy(busy), .rowOffset(rowOffset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mm[CELLS];
  bit known[CELLS];
  int fillQ[$];
  int off = 0;
  int fillVal = 0;

  task automatic checkEq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit inRng(input int c, input int r);
    return (c < COLS) && (r < ROWS);
  endfunction

  function automatic int pa(input int c, input int r);
    return ((r + off) % ROWS) * COLS + c;
  endfunction

  // One clock: predict reads from the pre-edge screen, update the model, compare after the edge.
  task automatic step();
    int expCpu, expVga, a;
    bit kc, kv;
    expCpu = 0; expVga = 0; kc = 1'b1; kv = 1'b1;
    if (!reset && inRng(int'(cpuCol), int'(cpuRow))) begin
      a = pa(int'(cpuCol), int'(cpuRow)); kc = known[a]; expCpu = mm[a];
    end
    if (!reset && inRng(int'(hGlyphVGA), int'(vGlyphVGA))) begin
      a = pa(int'(hGlyphVGA), int'(vGlyphVGA)); kv = known[a]; expVga = mm[a];
    end
    if (reset) begin
      fillQ.delete();
      off = 0;
    end else if (fillQ.size() > 0) begin
      a = fillQ.pop_front();
      mm[a] = fillVal; known[a] = 1'b1;
    end else begin
      if (cpuWriteEn && inRng(int'(cpuCol), int'(cpuRow)) && !clearStart) begin
        a = pa(int'(cpuCol), int'(cpuRow)); mm[a] = int'(writeData); known[a] = 1'b1;
      end
      if (clearStart) begin
        fillVal = int'(fillChar); off = 0;
        for (int i = 0; i < CELLS; i++) fillQ.push_back(i);
      end else if (scrollUp) begin
        fillVal = int'(fillChar);
        for (int c = 0; c < COLS; c++) fillQ.push_back(off * COLS + c);
        off = (off + 1) % ROWS;
      end
    end
    @(posedge clk); #1;
    if (kc) checkEq("cpuRead", int'(outputCPU), expCpu);
    if (kv) checkEq("vgaRead", int'(outputVGA), expVga);
    checkEq("busy", int'(busy), int'(fillQ.size() > 0));
    checkEq("cpuReady", int'(cpuReady), int'(fillQ.size() == 0));
    checkEq("rowOffset", int'(rowOffset), off);
  endtask

  task automatic randInputs();
    cpuWriteEn = 1'($urandom_range(0, 1));
    cpuCol     = 7'($urandom_range(0, 85));
    cpuRow     = 6'($urandom_range(0, 63));
    writeData  = 7'($urandom);
    hGlyphVGA  = 7'($urandom_range(0, 85));
    vGlyphVGA  = 6'($urandom_range(0, 63));
    fillChar   = 7'($urandom);
  endtask

  task automatic quiet();
    cpuWriteEn = 1'b0; clearStart = 1'b0; scrollUp = 1'b0;
  endtask

  // Issue a command pulse, then run random traffic until the fill finishes; returns busy length.
  task automatic runCmd(input bit clr, input bit scr, input int fc, output int n);
    clearStart = clr; scrollUp = scr; fillChar = 7'(fc);
    step();
    clearStart = 1'b0; scrollUp = 1'b0;
    n = 0;
    while (busy && n < 6000) begin
      randInputs();
      clearStart = 1'($urandom_range(0, 7) == 0);
      scrollUp   = 1'($urandom_range(0, 7) == 0);
      step();
      n++;
    end
    quiet();
  endtask

  task automatic readAt(input int c, input int r);
    cpuCol = 7'(c); cpuRow = 6'(r); hGlyphVGA = 7'(c); vGlyphVGA = 6'(r);
    step();
  endtask

  initial begin
    int n;
    quiet();
    step(); step();
    reset = 1'b0;
    checkEq("rstOutCPU", int'(outputCPU), 0);
    checkEq("rstOutVGA", int'(outputVGA), 0);
    checkEq("rstReady", int'(cpuReady), 1);

    // full clear with 0x20, CPU writes during busy must be dropped
    runCmd(1'b1, 1'b0, 32'h20, n);
    checkEq("clearLen", n, CELLS);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cpuCol = 7'(c); cpuRow = 6'(r);
        hGlyphVGA = 7'((c + 7) % COLS); vGlyphVGA = 6'((r + 3) % ROWS);
        step();
      end
    checkEq("clearCell", int'(outputCPU), 32'h20);

    // basic write then read, and read-during-write returns old data
    cpuWriteEn = 1'b1; cpuCol = 7'd5; cpuRow = 6'd2; writeData = 7'h41;
    step();
    cpuWriteEn = 1'b0; hGlyphVGA = 7'd5; vGlyphVGA = 6'd2;
    step();
    checkEq("wr41cpu", int'(outputCPU), 32'h41);
    checkEq("wr41vga", int'(outputVGA), 32'h41);
    cpuWriteEn = 1'b1; writeData = 7'h11;
    step();
    checkEq("rdwOld", int'(outputCPU), 32'h41);
    cpuWriteEn = 1'b0;
    step();
    checkEq("rdwNew", int'(outputVGA), 32'h11);

    // tag rows, scroll once with blank fill
    for (int r = 0; r < ROWS; r++) begin
      cpuWriteEn = 1'b1; cpuCol = 7'd0; cpuRow = 6'(r); writeData = 7'(r);
      step();
    end
    quiet();
    runCmd(1'b0, 1'b1, 32'h0, n);
    checkEq("scrollLen", n, COLS);
    checkEq("scrollOff", int'(rowOffset), 1);
    for (int r = 0; r < ROWS; r++) readAt(0, r);
    for (int c = 0; c < COLS; c++) readAt(c, ROWS - 1);
    checkEq("row59", int'(outputCPU), 0);
    readAt(0, 10);
    checkEq("row10", int'(outputCPU), 11);

    // 60 scrolls: offset wraps back around
    for (int k = 0; k < ROWS; k++) begin
      runCmd(1'b0, 1'b1, int'($urandom_range(0, 127)), n);
      checkEq("scrollLenK", n, COLS);
      for (int j = 0; j < 4; j++) begin
        randInputs(); step();
      end
      quiet();
    end
    checkEq("wrapOff", int'(rowOffset), 1);

    // random idle traffic with occasional scrolls
    for (int i = 0; i < 1500; i++) begin
      randInputs();
      scrollUp = 1'($urandom_range(0, 99) == 0);
      step();
    end
    quiet();
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    checkEq("idleAfterRand", int'(busy), 0);

    // clear and scroll together: clear wins
    runCmd(1'b1, 1'b1, int'($urandom_range(0, 127)), n);
    checkEq("bothLen", n, CELLS);
    checkEq("bothOff", int'(rowOffset), 0);

    // reset abort at fill cycle 100
    cpuWriteEn = 1'b1; cpuCol = 7'd20; cpuRow = 6'd1; writeData = 7'h55; step();
    cpuCol = 7'd19; writeData = 7'h33; step();
    quiet();
    clearStart = 1'b1; fillChar = 7'h2A; step();
    clearStart = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1; step();
    reset = 1'b0;
    checkEq("abortBusy", int'(busy), 0);
    checkEq("abortReady", int'(cpuReady), 1);
    checkEq("abortOff", int'(rowOffset), 0);
    readAt(19, 1);
    checkEq("cell99", int'(outputCPU), 32'h2A);
    readAt(20, 1);
    checkEq("cell100", int'(outputCPU), 32'h55);
    readAt(80, 0);
    checkEq("oobRead", int'(outputVGA), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
